srio_swrite_unpack_logic: RTL and testbench
===========================================

SRIO_SWRITE_UNPACK_LOGIC -- requirements
Module: srio_swrite_unpack_logic

Interface
REQ-001 Parameter MAX_PAYLOAD, default 32, SHALL set the maximum payload words (64-bit) per packet.
REQ-002 Parameter PKT_TYPE, default 4'b0110, SHALL set the accepted FTYPE (SWRITE).
REQ-003 AXIS_ACLK  in  1  SHALL be the single clock; all logic on its rising edge.
REQ-004 AXIS_ARESETN  in  1  SHALL be the reset: asynchronous assert, active-low.
REQ-005 S_AXIS_TVALID/S_AXIS_TREADY/S_AXIS_TLAST  in/out/in  1 each  SHALL form the packet-input handshake: header word then payload words.
REQ-006 S_AXIS_TDATA  in  64  SHALL carry header/payload; header FTYPE=[55:52], address=[31:0].
REQ-007 S_AXIS_TUSER  in  32  SHALL carry {src,dest}, sampled with the header.
REQ-008 M_AXIS_TVALID/M_AXIS_TREADY/M_AXIS_TLAST  out/in/out  1 each  SHALL form the payload-output handshake.
REQ-009 M_AXIS_TDATA  out  64  SHALL carry payload words only.
REQ-010 cmd  in  32  SHALL control: bit0 enable, bit1 clear; other bits ignored.
REQ-011 addr_out, srcdest_out  out  32 each  SHALL hold address and TUSER of the last accepted header.
REQ-012 pkt_cnt, err_cnt  out  16 each  SHALL count accepted packets and errored packets.

Function
REQ-013 States SHALL be IDLE, HDR, PAYLOAD, DROP; transfer = TVALID & TREADY.
REQ-014 IDLE: S_AXIS_TREADY=0; SHALL go to HDR in the cycle after cmd[0]=1 is sampled.
REQ-015 HDR: S_AXIS_TREADY=1; on transfer with FTYPE==PKT_TYPE and TLAST=0 SHALL latch addr_out/srcdest_out, pkt_cnt+1, zero the word count, go to PAYLOAD.
REQ-016 HDR: on transfer with FTYPE!=PKT_TYPE and TLAST=0 SHALL increment err_cnt and go to DROP; with TLAST=1 (any type, empty packet) SHALL increment err_cnt and stay in HDR.
REQ-017 Output SHALL be one register stage: M_AXIS_TVALID/TDATA/TLAST registered; PAYLOAD S_AXIS_TREADY = !M_AXIS_TVALID | M_AXIS_TREADY.
REQ-018 PAYLOAD: each input transfer SHALL load the output register, increment the word count; latency input→M_AXIS_TVALID = 1 cycle.
REQ-019 M_AXIS_TLAST SHALL be S_AXIS_TLAST of the word, or 1 when it is word MAX_PAYLOAD.
REQ-020 PAYLOAD: input TLAST transfer SHALL return to HDR; word MAX_PAYLOAD without TLAST SHALL increment err_cnt and go to DROP.
REQ-021 DROP: S_AXIS_TREADY=1, nothing forwarded; TLAST transfer SHALL go to HDR.
REQ-022 Output register SHALL hold TDATA/TLAST stable while M_AXIS_TVALID=1 and M_AXIS_TREADY=0; simultaneous drain and load SHALL be lossless at full throughput.
REQ-023 cmd[0]=0 SHALL take effect only in HDR (return to IDLE at packet boundary); packets in flight complete.
REQ-024 cmd[1]=1 SHALL, next cycle, force IDLE, clear M_AXIS_TVALID, word count, pkt_cnt, err_cnt; overrides all other events.
REQ-025 pkt_cnt and err_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-026 AXIS_ARESETN=0 SHALL immediately force IDLE, all outputs and counters 0, S_AXIS_TREADY=0, M_AXIS_TVALID=0, mid-packet state discarded.
REQ-027 After deassertion the block SHALL remain in IDLE until cmd[0]=1.

Verification
REQ-028 Enable, header FTYPE=6 addr=0x1000_0040 TUSER=0x0012_0034, 4 payload words last on 4th, M_AXIS_TREADY=1 -> 4 words out, TLAST on 4th, addr_out=0x1000_0040, pkt_cnt=1, err_cnt=0.
REQ-029 Header FTYPE=5 + 3 words -> nothing on M_AXIS, err_cnt=1, next valid packet forwarded intact.
REQ-030 Header + 40 words, TLAST on 40th -> 32 words out, TLAST on 32nd, words 33-40 consumed, err_cnt=1.
REQ-031 Random M_AXIS_TREADY (50%) over 100 packets of 1-32 words -> output equals input payload exactly, pkt_cnt=100.
REQ-032 cmd[1] pulse mid-payload, then AXIS_ARESETN low mid-payload -> IDLE, M_AXIS_TVALID=0, counters 0, in each case.

Source files
------------

// File: rtl/srio_swrite_unpack_logic_if.sv
// Stream pair for the SWRITE unpacker: packet input (header + payload) and payload output.
// The slave modport is the unpacker's view; master is the view of whatever surrounds it.
interface srio_swrite_unpack_logic_if;
  logic        S_AXIS_TVALID;
  logic        S_AXIS_TREADY;
  logic        S_AXIS_TLAST;
  logic [63:0] S_AXIS_TDATA;
  logic [31:0] S_AXIS_TUSER;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY;
  logic        M_AXIS_TLAST;
  logic [63:0] M_AXIS_TDATA;

  modport slave (
    input  S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TDATA, S_AXIS_TUSER, M_AXIS_TREADY,
    output S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA
  );

  modport master (
    output S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TDATA, S_AXIS_TUSER, M_AXIS_TREADY,
    input  S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA
  );
endinterface

// File: rtl/srio_swrite_unpack_logic.sv
// Strips SWRITE headers off an incoming packet stream and forwards the payload through one
// output register; tracks the last header's address/route and good/errored packet counts.
//
// state   | meaning
// IDLE    | disabled, input not accepted
// HDR     | waiting for a header word
// PAYLOAD | forwarding payload words of an accepted packet
// DROP    | discarding the rest of a rejected or oversized packet
module srio_swrite_unpack_logic #(
  parameter int unsigned MAX_PAYLOAD = 32,
  parameter logic [3:0]  PKT_TYPE    = 4'b0110
) (
  input  logic                             AXIS_ACLK,
  input  logic                             AXIS_ARESETN,
  srio_swrite_unpack_logic_if.slave        axis_if,
  input  logic [31:0]                      cmd,
  output logic [31:0]                      addr_out,
  output logic [31:0]                      srcdest_out,
  output logic [15:0]                      pkt_cnt,
  output logic [15:0]                      err_cnt
);
  localparam int unsigned    WCW    = $clog2(MAX_PAYLOAD + 1);
  localparam logic [WCW-1:0] WC_MAX = WCW'(MAX_PAYLOAD);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DROP} state_t;

  state_t         state_q, state_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    srcdest_q, srcdest_d;
  logic [15:0]    pkt_cnt_q, pkt_cnt_d;
  logic [15:0]    err_cnt_q, err_cnt_d;
  logic           m_valid_q, m_valid_d;
  logic           m_last_q, m_last_d;
  logic [63:0]    m_data_q, m_data_d;

  logic           s_ready;
  logic           s_xfer;
  logic           m_drain;
  logic           hdr_ok;
  logic           wc_full;
  logic [WCW-1:0] wcnt_inc;
  logic           pkt_inc;
  logic           err_inc;
  logic           unused_cmd;

  assign unused_cmd = ^cmd[31:2];

  assign s_xfer   = axis_if.S_AXIS_TVALID & s_ready;
  assign m_drain  = m_valid_q & axis_if.M_AXIS_TREADY;
  assign hdr_ok   = (axis_if.S_AXIS_TDATA[55:52] == PKT_TYPE);
  assign wcnt_inc = wcnt_q + WCW'(1);
  assign wc_full  = (wcnt_inc == WC_MAX);

  // Payload is back-pressured only by the output register: it accepts when empty or draining.
  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      S_HDR:     s_ready = 1'b1;
      S_PAYLOAD: s_ready = ~m_valid_q | axis_if.M_AXIS_TREADY;
      S_DROP:    s_ready = 1'b1;
      default:   s_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    addr_d    = addr_q;
    srcdest_d = srcdest_q;
    m_valid_d = m_valid_q & ~m_drain;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    pkt_inc   = 1'b0;
    err_inc   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd[0]) state_d = S_HDR;
      end
      S_HDR: begin
        if (s_xfer) begin
          if (axis_if.S_AXIS_TLAST) begin
            err_inc = 1'b1;
          end else if (hdr_ok) begin
            addr_d    = axis_if.S_AXIS_TDATA[31:0];
            srcdest_d = axis_if.S_AXIS_TUSER;
            pkt_inc   = 1'b1;
            wcnt_d    = '0;
            state_d   = S_PAYLOAD;
          end else begin
            err_inc = 1'b1;
            state_d = S_DROP;
          end
        end else if (!cmd[0]) begin
          state_d = S_IDLE;
        end
      end
      S_PAYLOAD: begin
        if (s_xfer) begin
          m_valid_d = 1'b1;
          m_data_d  = axis_if.S_AXIS_TDATA;
          m_last_d  = axis_if.S_AXIS_TLAST | wc_full;
          wcnt_d    = wcnt_inc;
          if (axis_if.S_AXIS_TLAST) begin
            state_d = S_HDR;
          end else if (wc_full) begin
            err_inc = 1'b1;
            state_d = S_DROP;
          end
        end
      end
      S_DROP: begin
        if (s_xfer && axis_if.S_AXIS_TLAST) state_d = S_HDR;
      end
      default: state_d = S_IDLE;
    endcase

    pkt_cnt_d = (pkt_inc && pkt_cnt_q != 16'hFFFF) ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
    err_cnt_d = (err_inc && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;

    // Clear wins over every other event, including a transfer in the same cycle.
    if (cmd[1]) begin
      state_d   = S_IDLE;
      m_valid_d = 1'b0;
      wcnt_d    = '0;
      pkt_cnt_d = '0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      addr_q    <= '0;
      srcdest_q <= '0;
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      addr_q    <= addr_d;
      srcdest_q <= srcdest_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
    end
  end

  assign axis_if.S_AXIS_TREADY = s_ready;
  assign axis_if.M_AXIS_TVALID = m_valid_q;
  assign axis_if.M_AXIS_TLAST  = m_last_q;
  assign axis_if.M_AXIS_TDATA  = m_data_q;
  assign addr_out              = addr_q;
  assign srcdest_out           = srcdest_q;
  assign pkt_cnt               = pkt_cnt_q;
  assign err_cnt               = err_cnt_q;
endmodule

// File: tb/tb_srio_swrite_unpack_logic.sv
// Directed bench for the SWRITE unpacker: payload scoreboard, hold-stability monitor,
// overflow/drop/empty-packet cases, random output back-pressure, clear and reset mid-packet.
module tb_srio_swrite_unpack_logic;
  logic        AXIS_ACLK = 1'b0;
  logic        AXIS_ARESETN;
  logic [31:0] cmd;
  logic [31:0] addr_out;
  logic [31:0] srcdest_out;
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;

  always #5 AXIS_ACLK = ~AXIS_ACLK;

  srio_swrite_unpack_logic_if axis_if ();

  srio_swrite_unpack_logic #(
    .MAX_PAYLOAD (32),
    .PKT_TYPE    (4'b0110)
  ) dut (
    .AXIS_ACLK    (AXIS_ACLK),
    .AXIS_ARESETN (AXIS_ARESETN),
    .axis_if      (axis_if),
    .cmd          (cmd),
    .addr_out     (addr_out),
    .srcdest_out  (srcdest_out),
    .pkt_cnt      (pkt_cnt),
    .err_cnt      (err_cnt)
  );

  int          n_checks;
  int          n_errors;
  int          n_out;
  int          rdy_mode;   // 0: always ready, 1: random, 2: stalled
  logic [64:0] exp_q[$];

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_hdr(input logic [3:0] ft, input logic [31:0] a);
    return {8'h00, ft, 20'h0, a};
  endfunction

  task automatic to_drive();
    @(posedge AXIS_ACLK);
    #1;
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge AXIS_ACLK);
      #1;
      case (rdy_mode)
        1:       axis_if.M_AXIS_TREADY = 1'($urandom_range(0, 1));
        2:       axis_if.M_AXIS_TREADY = 1'b0;
        default: axis_if.M_AXIS_TREADY = 1'b1;
      endcase
    end
  endtask

  task automatic monitor();
    logic [64:0] cur;
    logic [64:0] held;
    logic [64:0] e;
    logic        held_v;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge AXIS_ACLK);
      if (axis_if.M_AXIS_TVALID) begin
        cur = {axis_if.M_AXIS_TLAST, axis_if.M_AXIS_TDATA};
        if (held_v) chk("hold_stable", cur, held);
        if (axis_if.M_AXIS_TREADY) begin
          held_v = 1'b0;
          n_out++;
          if (exp_q.size() == 0) begin
            chk("spurious_out", 65'(exp_q.size()), 65'd1);
          end else begin
            e = exp_q.pop_front();
            chk("out_word", cur, e);
          end
        end else begin
          held_v = 1'b1;
          held   = cur;
        end
      end else begin
        held_v = 1'b0;
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the word has transferred.
  task automatic send_word(input logic [63:0] d, input logic l, input logic [31:0] u);
    int cyc;
    cyc = 0;
    axis_if.S_AXIS_TVALID = 1'b1;
    axis_if.S_AXIS_TDATA  = d;
    axis_if.S_AXIS_TLAST  = l;
    axis_if.S_AXIS_TUSER  = u;
    forever begin
      @(negedge AXIS_ACLK);
      if (axis_if.S_AXIS_TREADY) break;
      cyc++;
      if (cyc > 300) begin
        chk("send_timeout", 65'(cyc), 65'd0);
        break;
      end
      to_drive();
    end
    to_drive();
    axis_if.S_AXIS_TVALID = 1'b0;
    axis_if.S_AXIS_TLAST  = 1'b0;
  endtask

  task automatic send_pkt(input logic [3:0] ft, input logic [31:0] a, input logic [31:0] u,
                          input int n, input bit fwd);
    logic [63:0] d;
    send_word(mk_hdr(ft, a), n == 0, u);
    for (int i = 1; i <= n; i++) begin
      d = {$urandom(), $urandom()};
      if (fwd && i <= 32) exp_q.push_back({(i == n) || (i == 32), d});
      send_word(d, i == n, u);
    end
  endtask

  // Returns at a negedge once the scoreboard is empty and the output register is idle.
  task automatic wait_drain();
    int cyc;
    cyc = 0;
    do begin
      @(negedge AXIS_ACLK);
      cyc++;
    end while ((exp_q.size() != 0 || axis_if.M_AXIS_TVALID) && cyc < 2000);
    chk("drain_q_empty", 65'(exp_q.size()), 65'd0);
  endtask

  initial begin
    int base;
    int total;
    int len;
    n_checks = 0;
    n_errors = 0;
    n_out    = 0;
    rdy_mode = 0;
    AXIS_ARESETN = 1'b0;
    cmd = 32'h0;
    axis_if.S_AXIS_TVALID = 1'b0;
    axis_if.S_AXIS_TDATA  = '0;
    axis_if.S_AXIS_TLAST  = 1'b0;
    axis_if.S_AXIS_TUSER  = '0;
    axis_if.M_AXIS_TREADY = 1'b1;
    fork
      monitor();
      ready_drv();
      begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(negedge AXIS_ACLK);
    chk("rst_s_tready", 65'(axis_if.S_AXIS_TREADY), 65'd0);
    chk("rst_m_tvalid", 65'(axis_if.M_AXIS_TVALID), 65'd0);
    chk("rst_pkt_cnt", 65'(pkt_cnt), 65'd0);
    chk("rst_err_cnt", 65'(err_cnt), 65'd0);
    chk("rst_addr_out", 65'(addr_out), 65'd0);
    to_drive();
    AXIS_ARESETN = 1'b1;
    repeat (3) to_drive();
    @(negedge AXIS_ACLK);
    chk("idle_after_rst", 65'(axis_if.S_AXIS_TREADY), 65'd0);

    // enable: HDR appears in the cycle after cmd[0] is sampled
    to_drive();
    cmd = 32'h1;
    @(negedge AXIS_ACLK);
    chk("idle_before_sample", 65'(axis_if.S_AXIS_TREADY), 65'd0);
    to_drive();
    @(negedge AXIS_ACLK);
    chk("hdr_ready", 65'(axis_if.S_AXIS_TREADY), 65'd1);
    to_drive();

    // basic 4-word packet
    base = n_out;
    send_pkt(4'h6, 32'h1000_0040, 32'h0012_0034, 4, 1'b1);
    wait_drain();
    chk("p1_nout", 65'(n_out - base), 65'd4);
    chk("p1_addr", 65'(addr_out), 65'h1000_0040);
    chk("p1_srcdest", 65'(srcdest_out), 65'h0012_0034);
    chk("p1_pkt_cnt", 65'(pkt_cnt), 65'd1);
    chk("p1_err_cnt", 65'(err_cnt), 65'd0);
    to_drive();

    // wrong FTYPE dropped, following good packet intact
    base = n_out;
    send_pkt(4'h5, 32'h2000_0000, 32'h0001_0002, 3, 1'b0);
    send_pkt(4'h6, 32'h3000_0080, 32'h00AB_00CD, 2, 1'b1);
    wait_drain();
    chk("p2_nout", 65'(n_out - base), 65'd2);
    chk("p2_err_cnt", 65'(err_cnt), 65'd1);
    chk("p2_pkt_cnt", 65'(pkt_cnt), 65'd2);
    chk("p2_addr", 65'(addr_out), 65'h3000_0080);
    chk("p2_srcdest", 65'(srcdest_out), 65'h00AB_00CD);
    to_drive();

    // empty packet: header with TLAST
    send_pkt(4'h6, 32'h4000_0000, 32'h0003_0004, 0, 1'b0);
    @(negedge AXIS_ACLK);
    chk("empty_err_cnt", 65'(err_cnt), 65'd2);
    chk("empty_pkt_cnt", 65'(pkt_cnt), 65'd2);
    chk("empty_addr_kept", 65'(addr_out), 65'h3000_0080);
    chk("empty_stay_hdr", 65'(axis_if.S_AXIS_TREADY), 65'd1);
    to_drive();

    // oversize: 40 words, 32 forwarded, rest dropped
    base = n_out;
    send_pkt(4'h6, 32'h5000_0000, 32'h0005_0006, 40, 1'b1);
    wait_drain();
    chk("ovf_nout", 65'(n_out - base), 65'd32);
    chk("ovf_err_cnt", 65'(err_cnt), 65'd3);
    chk("ovf_pkt_cnt", 65'(pkt_cnt), 65'd3);
    to_drive();
    base = n_out;
    send_pkt(4'h6, 32'h5000_0100, 32'h0007_0008, 1, 1'b1);
    send_pkt(4'h6, 32'h5000_0200, 32'h0009_000A, 32, 1'b1);
    wait_drain();
    chk("after_ovf_nout", 65'(n_out - base), 65'd33);
    chk("max_len_err_cnt", 65'(err_cnt), 65'd3);
    chk("max_len_pkt_cnt", 65'(pkt_cnt), 65'd5);
    to_drive();

    // disable at packet boundary
    cmd = 32'h0;
    repeat (2) to_drive();
    @(negedge AXIS_ACLK);
    chk("disable_idle", 65'(axis_if.S_AXIS_TREADY), 65'd0);
    to_drive();

    // clear counters, then 100 packets under random back-pressure
    cmd = 32'h3;
    to_drive();
    cmd = 32'h1;
    @(negedge AXIS_ACLK);
    chk("clr_pkt_cnt", 65'(pkt_cnt), 65'd0);
    chk("clr_err_cnt", 65'(err_cnt), 65'd0);
    to_drive();
    rdy_mode = 1;
    base  = n_out;
    total = 0;
    for (int p = 0; p < 100; p++) begin
      len = int'($urandom_range(1, 32));
      total += len;
      send_pkt(4'h6, 32'h6000_0000 + 32'(p), 32'(p), len, 1'b1);
    end
    wait_drain();
    chk("rnd_nout", 65'(n_out - base), 65'(total));
    chk("rnd_pkt_cnt", 65'(pkt_cnt), 65'd100);
    chk("rnd_err_cnt", 65'(err_cnt), 65'd0);
    to_drive();

    // clear mid-payload with the output stalled
    rdy_mode = 2;
    repeat (2) to_drive();
    send_word(mk_hdr(4'h6, 32'h7000_0000), 1'b0, 32'h0011_0022);
    send_word(64'hDEAD_BEEF_0000_0001, 1'b0, 32'h0011_0022);
    @(negedge AXIS_ACLK);
    chk("pre_clr_mvalid", 65'(axis_if.M_AXIS_TVALID), 65'd1);
    chk("pre_clr_pkt_cnt", 65'(pkt_cnt), 65'd101);
    to_drive();
    cmd = 32'h3;
    to_drive();
    cmd = 32'h0;
    @(negedge AXIS_ACLK);
    chk("clr_mvalid", 65'(axis_if.M_AXIS_TVALID), 65'd0);
    chk("clr_idle", 65'(axis_if.S_AXIS_TREADY), 65'd0);
    chk("clr2_pkt_cnt", 65'(pkt_cnt), 65'd0);
    chk("clr2_err_cnt", 65'(err_cnt), 65'd0);
    to_drive();

    // asynchronous reset mid-payload
    cmd = 32'h1;
    repeat (2) to_drive();
    send_pkt(4'h6, 32'h7100_0000, 32'h0033_0044, 0, 1'b0);
    send_word(mk_hdr(4'h6, 32'h7200_0000), 1'b0, 32'h0055_0066);
    send_word(64'hDEAD_BEEF_0000_0002, 1'b0, 32'h0055_0066);
    @(negedge AXIS_ACLK);
    chk("pre_rst_mvalid", 65'(axis_if.M_AXIS_TVALID), 65'd1);
    chk("pre_rst_pkt_cnt", 65'(pkt_cnt), 65'd1);
    chk("pre_rst_err_cnt", 65'(err_cnt), 65'd1);
    to_drive();
    cmd = 32'h0;
    AXIS_ARESETN = 1'b0;
    #1;
    chk("arst_mvalid", 65'(axis_if.M_AXIS_TVALID), 65'd0);
    chk("arst_s_tready", 65'(axis_if.S_AXIS_TREADY), 65'd0);
    chk("arst_pkt_cnt", 65'(pkt_cnt), 65'd0);
    chk("arst_err_cnt", 65'(err_cnt), 65'd0);
    chk("arst_addr", 65'(addr_out), 65'd0);
    to_drive();
    AXIS_ARESETN = 1'b1;
    repeat (3) to_drive();
    @(negedge AXIS_ACLK);
    chk("arst_stay_idle", 65'(axis_if.S_AXIS_TREADY), 65'd0);
    chk("arst_q_empty", 65'(exp_q.size()), 65'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
